// File: rtl/serial_tx_shifter.sv
// serial_tx_shifter: parallel-to-serial frame transmitter.
// Accepts a WIDTH-bit word over valid/ready and shifts it out MSB first,
// holding each bit for DIV clocks with sframe high, then idles for
// GAP_BITS bit-times before pulsing done.
// Optional build macro: SERIAL_TX_PARITY_EN appends an even-parity bit
// after the LSB (frame becomes WIDTH+1 bits).
module serial_tx_shifter #(
  parameter int WIDTH    = 8,
  parameter int DIV      = 4,
  parameter int GAP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sdata,
  output logic             sframe,
  output logic             busy,
  output logic             done
);

`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  // One counter serves both the data-bit index and the gap-bit index, so it
  // is sized for whichever of the two terminal values is larger.
  localparam int CNT_MAX = (NBITS > GAP_BITS) ? (NBITS - 1) : (GAP_BITS - 1);
  localparam int BIT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NBITS - 1);
  localparam logic [BIT_W-1:0] LAST_GAP = BIT_W'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NBITS-1:0]   shift_q, shift_d;
  logic [DIV_W-1:0]   div_q,   div_d;
  logic [BIT_W-1:0]   bit_q,   bit_d;
  logic               sframe_q, sframe_d;
  logic               done_q,   done_d;
  logic [NBITS-1:0]   load_word;
  logic               div_wrap;

  // The parity bit rides at the bottom of the shift register so it simply
  // follows the LSB out without any extra sequencing.
`ifdef SERIAL_TX_PARITY_EN
  assign load_word = {in_data, ^in_data};
`else
  assign load_word = in_data;
`endif

  assign div_wrap = (div_q == DIV_LAST);

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      sframe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sframe_q <= sframe_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: accept in IDLE, pace bits by DIV, then run the gap.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sframe_d = sframe_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        sframe_d = 1'b0;
        if (in_valid) begin
          state_d  = SHIFT;
          shift_d  = load_word;
          div_d    = '0;
          bit_d    = '0;
          sframe_d = 1'b1;
        end
      end
      SHIFT: begin
        if (div_wrap) begin
          div_d   = '0;
          // Shifting in zeros leaves the register clear once the last bit
          // has gone, which keeps sdata low in GAP and IDLE.
          shift_d = shift_q << 1;
          if (bit_q == LAST_BIT) begin
            bit_d    = '0;
            sframe_d = 1'b0;
            if (GAP_BITS > 0) begin
              state_d = GAP;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (div_wrap) begin
          div_d = '0;
          if (bit_q == LAST_GAP) begin
            bit_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        shift_d  = '0;
        div_d    = '0;
        bit_d    = '0;
        sframe_d = 1'b0;
      end
    endcase
  end

  assign sdata    = shift_q[NBITS-1];
  assign sframe   = sframe_q;
  assign done     = done_q;
  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

endmodule

// File: doc/serial_tx_shifter.md
Name: serial_tx_shifter

Overview:
Parallel-to-serial frame transmitter, the launching end of our sampled serial link. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, holding each bit for DIV clocks. A single `sframe` qualifier is high during data bits, so the receiving side can capture each bit with a plain rising-edge flop. An inter-frame gap follows each frame.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DIV, 4, clocks per serial bit (>=1)
GAP_BITS, 1, idle bit-times after each frame (>=0; 0 = no gap)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
in_data  input  WIDTH  parallel word to send
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word
sdata  output  1  serial data, registered
sframe  output  1  high while a data (or parity) bit is on sdata, registered
busy  output  1  frame or gap in progress
done  output  1  one-cycle pulse when a frame plus its gap completes

Behaviour:
- Reset: state=IDLE, shift reg=0, bit/div counters=0, sdata=0, sframe=0, busy=0, done=0. Reset is asynchronous, active-high, and the clock is clk. Reset aborts any frame immediately; no partial completion and no done pulse.
- States:
  - IDLE: in_ready=1, busy=0. in_ready is decoded from state==IDLE, so it is 1 while in reset.
  - SHIFT: sframe=1, busy=1.
  - GAP: sdata=0, sframe=0, busy=1.
- Accept: when in_valid && in_ready at edge k, in_data is captured at edge k. in_data and in_valid are ignored outside IDLE.
- Latency: sframe=1 and sdata=in_data[WIDTH-1] are visible the cycle after edge k, i.e. 1-cycle launch latency.
- Bit timing:
  - Each bit is held exactly DIV cycles; a div counter runs 0..DIV-1.
  - At wrap, the word shifts left and the bit counter increments.
  - Bit order is MSB first, LSB last.
- SHIFT -> GAP after the last bit's DIV cycles, if GAP_BITS>0; the gap lasts GAP_BITS*DIV cycles.
- SHIFT or GAP -> IDLE at the end of the frame or gap. On the first IDLE cycle, done=1 for exactly one cycle.
- Back-to-back: done and in_ready coincide. If in_valid=1 in that cycle, the next frame's first bit appears the following cycle, with no dead cycle beyond the gap.
- GAP_BITS=0: SHIFT -> IDLE directly, and sframe drops for exactly the one IDLE cycle.
- DIV=1: one bit per clock, with the counter permanently at 0.
- Frame length: WIDTH*DIV cycles, plus DIV more if parity is enabled.
- Counters are sized as $clog2 of max+1. A counter never exceeds its terminal value; wrap is to 0.

Optional Feature:
Macro `SERIAL_TX_PARITY_EN`.
- Defined: an even-parity bit (XOR of the captured word) is appended after the LSB. It is held DIV cycles with sframe=1, so a frame is WIDTH+1 bits.
- Undefined: no parity bit and no parity logic; a frame is WIDTH bits.
- Port list is identical in both builds.

Test Plan:
- WIDTH=8, DIV=4, GAP_BITS=1, no parity; send 0xA5 accepted at edge 0:
  - cycles 1-32: sframe=1, sdata = 1,0,1,0,0,1,0,1, each held 4 cycles.
  - cycles 33-36: sframe=0, sdata=0, busy=1.
  - cycle 37: done=1, in_ready=1.
- Parity build, same config:
  - 0xA5: parity bit 0 in cycles 33-36.
  - 0x07: sdata=1 in cycles 33-36.
  - In both cases done lands at cycle 41.
- Hold in_valid=1 through a frame and change in_data mid-frame: only one accept occurs; the serial stream matches the word captured at accept. The second word is accepted in the done cycle and starts the next cycle.
- Assert rst at cycle 10 of a frame: sdata, sframe, busy and done drop to 0 asynchronously, and in_ready=1. After release, the next accepted word (0x3C) is sent cleanly from its MSB.
- DIV=1, GAP_BITS=0; stream 0xFF then 0x00 back-to-back: 8 cycles of 1, one cycle with sframe=0, then 8 cycles of 0; done is pulsed twice.
